// File: rtl/hps_reset_req_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package  : hps_reset_req_pkg
// Brief    : Shared types and bit indices for the HPS reset-request sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package hps_reset_req_pkg;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        PRESS0       = 3'd1,
        REQ          = 3'd2,
        WAIT_ASSERT  = 3'd3,
        WAIT_RELEASE = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        COLD  = 2'd0,
        WARM  = 2'd1,
        DEBUG = 2'd2
    } kind_t;

    localparam int EV_COLD    = 0;
    localparam int EV_WARM    = 1;
    localparam int EV_DEBUG   = 2;
    localparam int EV_TIMEOUT = 3;

    localparam int LED_ARMED   = 0;
    localparam int LED_COLD    = 1;
    localparam int LED_WARM    = 2;
    localparam int LED_TIMEOUT = 3;

    localparam int STM_W = 28;

    function automatic logic [1:0] ev_of(kind_t k);
        case (k)
            COLD:    return 2'(EV_COLD);
            WARM:    return 2'(EV_WARM);
            default: return 2'(EV_DEBUG);
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/hps_reset_req_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface : hps_reset_req_ctrl_if
// Brief     : f2h reset requests and h2f reset between fabric and HPS.
// Revision  : 1.0 - initial release
// ============================================================================
interface hps_reset_req_ctrl_if;

    logic f2h_cold_reset_req_n;
    logic f2h_warm_reset_req_n;
    logic f2h_debug_reset_req_n;
    logic h2f_reset_n;

    modport master (
        output f2h_cold_reset_req_n,
        output f2h_warm_reset_req_n,
        output f2h_debug_reset_req_n,
        input  h2f_reset_n
    );

    modport slave (
        input  f2h_cold_reset_req_n,
        input  f2h_warm_reset_req_n,
        input  f2h_debug_reset_req_n,
        output h2f_reset_n
    );

endinterface
`default_nettype wire

// File: rtl/hps_rst_debounce.sv
`default_nettype none
// ============================================================================
// Module   : hps_rst_debounce
// Brief    : Two-flop synchroniser, debouncer and press-edge detector.
// Revision : 1.0 - initial release
// ============================================================================
module hps_rst_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  wire  clk,
    input  wire  rst_n,
    input  wire  button_n,
    output logic level,
    output logic press_edge
);

    localparam int                 c_cnt_w    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

    logic [1:0]         r_sync;
    logic               r_level;
    logic               r_edge;
    logic [c_cnt_w-1:0] r_cnt;

    // Counter runs only while the synchronised input disagrees with the
    // accepted level; any agreement restarts the stability window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= 2'b11;
            r_level <= 1'b1;
            r_edge  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync <= {r_sync[0], button_n};
            r_edge <= 1'b0;
            if (r_sync[1] == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_last) begin
                r_cnt   <= '0;
                r_level <= r_sync[1];
                r_edge  <= r_level;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign level      = r_level;
    assign press_edge = r_edge;

endmodule
`default_nettype wire

// File: rtl/hps_reset_req_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hps_reset_req_ctrl
// Brief    : Button-driven sequencer for HPS cold/warm/debug reset requests.
// Revision : 1.0 - initial release
// ============================================================================
module hps_reset_req_ctrl
    import hps_reset_req_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES    = 50000,
    parameter int LONG_PRESS_CYCLES  = 100000000,
    parameter int REQ_PULSE_CYCLES   = 16,
    parameter int ACK_TIMEOUT_CYCLES = 50000000,
    parameter int CNT_W              = 27
) (
    input  wire                  clk_clk,
    input  wire                  reset_reset_n,
    input  wire  [1:0]           button_n,
    input  wire  [3:0]           dipsw,
    hps_reset_req_ctrl_if.master hps,
    output logic                 busy,
    output logic [3:0]           led,
    output logic [STM_W-1:0]     stm_hwevents
);

    localparam logic [CNT_W-1:0] c_long_last = CNT_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_pulse_end = CNT_W'(REQ_PULSE_CYCLES);
    localparam logic [CNT_W-1:0] c_ack_last  = CNT_W'(ACK_TIMEOUT_CYCLES - 1);

    logic [1:0] w_level;
    logic [1:0] w_press;
    logic       w_unused;

    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
        hps_rst_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk        (clk_clk),
            .rst_n      (reset_reset_n),
            .button_n   (button_n[gi]),
            .level      (w_level[gi]),
            .press_edge (w_press[gi])
        );
    end

    assign w_unused = &{1'b0, w_level[1], dipsw[3:1]};

    logic [1:0]       r_h2f_sync;
    state_t           r_state, w_state_nx;
    kind_t            r_kind, w_kind_nx;
    logic [CNT_W-1:0] r_cnt, w_cnt_nx;
    logic             w_timeout;
    logic             w_enter_req;
    logic             w_req_low;
    logic             r_cold_n, r_warm_n, r_debug_n;
    logic             r_busy;
    logic [3:0]       r_led;
    logic [3:0]       r_ev;

    always_comb begin
        w_state_nx = r_state;
        w_kind_nx  = r_kind;
        w_cnt_nx   = r_cnt;
        w_timeout  = 1'b0;
        case (r_state)
            IDLE: begin
                if (dipsw[0]) begin
                    if (w_press[0]) begin
                        w_state_nx = PRESS0;
                        w_cnt_nx   = '0;
                    end else if (w_press[1]) begin
                        w_kind_nx  = DEBUG;
                        w_state_nx = REQ;
                        w_cnt_nx   = '0;
                    end
                end
            end
            PRESS0: begin
                if (w_level[0]) begin
                    w_kind_nx  = WARM;
                    w_state_nx = REQ;
                    w_cnt_nx   = '0;
                end else if (r_cnt == c_long_last) begin
                    w_kind_nx  = COLD;
                    w_state_nx = REQ;
                    w_cnt_nx   = '0;
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            REQ: begin
                if (r_cnt == c_pulse_end) begin
                    w_state_nx = (r_kind == DEBUG) ? IDLE : WAIT_ASSERT;
                    w_cnt_nx   = '0;
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            WAIT_ASSERT, WAIT_RELEASE: begin
                // Handshake completion is checked before the timeout so it wins a tie.
                w_cnt_nx = r_cnt + 1'b1;
                if (r_state == WAIT_RELEASE && r_h2f_sync[1]) begin
                    w_state_nx = IDLE;
                    w_cnt_nx   = '0;
                end else if (r_cnt == c_ack_last) begin
                    w_state_nx = IDLE;
                    w_cnt_nx   = '0;
                    w_timeout  = 1'b1;
                end else if (r_state == WAIT_ASSERT && !r_h2f_sync[1]) begin
                    w_state_nx = WAIT_RELEASE;
                end
            end
            default: begin
                w_state_nx = IDLE;
                w_cnt_nx   = '0;
            end
        endcase
    end

    assign w_enter_req = (w_state_nx == REQ) && (r_state != REQ);
    // The entry cycle itself is skipped, so the pulse spans counts 1..REQ_PULSE_CYCLES.
    assign w_req_low   = (r_state == REQ) && (r_cnt != c_pulse_end);

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_h2f_sync <= 2'b11;
            r_state    <= IDLE;
            r_kind     <= COLD;
            r_cnt      <= '0;
            r_cold_n   <= 1'b1;
            r_warm_n   <= 1'b1;
            r_debug_n  <= 1'b1;
            r_busy     <= 1'b0;
            r_led      <= '0;
            r_ev       <= '0;
        end else begin
            r_h2f_sync <= {r_h2f_sync[0], hps.h2f_reset_n};
            r_state    <= w_state_nx;
            r_kind     <= w_kind_nx;
            r_cnt      <= w_cnt_nx;
            r_cold_n   <= !(w_req_low && r_kind == COLD);
            r_warm_n   <= !(w_req_low && r_kind == WARM);
            r_debug_n  <= !(w_req_low && r_kind == DEBUG);
            r_busy     <= (w_state_nx != IDLE);
            r_led[LED_ARMED] <= dipsw[0];
            r_ev <= '0;
            if (w_enter_req) begin
                r_ev[ev_of(w_kind_nx)] <= 1'b1;
            end
            if (w_enter_req && w_kind_nx == COLD) begin
                r_led[LED_COLD] <= 1'b1;
            end
            if (w_enter_req && w_kind_nx == WARM) begin
                r_led[LED_WARM] <= 1'b1;
            end
            if (w_timeout) begin
                r_ev[EV_TIMEOUT]    <= 1'b1;
                r_led[LED_TIMEOUT]  <= 1'b1;
            end
        end
    end

    assign hps.f2h_cold_reset_req_n  = r_cold_n;
    assign hps.f2h_warm_reset_req_n  = r_warm_n;
    assign hps.f2h_debug_reset_req_n = r_debug_n;
    assign busy                      = r_busy;
    assign led                       = r_led;
    assign stm_hwevents              = {{(STM_W-4){1'b0}}, r_ev};

endmodule
`default_nettype wire

// File: tb/tb_hps_reset_req_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hps_reset_req_ctrl
// Brief    : Directed scoreboard bench for hps_reset_req_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hps_reset_req_ctrl;

    localparam int DEB   = 4;
    localparam int LONG  = 64;
    localparam int PULSE = 16;
    localparam int ACK   = 200;

    // Event ids: 0..2 = cold/warm/debug req_n low pulse, 10+b = stm_hwevents[b] pulse
    typedef struct {
        int id;
        int len;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  button_n = 2'b11;
    logic [3:0]  dipsw = 4'b0001;
    logic        busy;
    logic [3:0]  led;
    logic [27:0] stm_hwevents;

    int   checks = 0;
    int   errors = 0;
    ev_t  exp_q[$];
    int   run_req[3];
    int   run_ev[4];

    hps_reset_req_ctrl_if hps ();

    hps_reset_req_ctrl #(
        .DEBOUNCE_CYCLES    (DEB),
        .LONG_PRESS_CYCLES  (LONG),
        .REQ_PULSE_CYCLES   (PULSE),
        .ACK_TIMEOUT_CYCLES (ACK),
        .CNT_W              (27)
    ) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .button_n      (button_n),
        .dipsw         (dipsw),
        .hps           (hps),
        .busy          (busy),
        .led           (led),
        .stm_hwevents  (stm_hwevents)
    );

    always #10 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (checks=%0d)", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_ev(input int id, input int len);
        ev_t e;
        e.id  = id;
        e.len = len;
        exp_q.push_back(e);
    endtask

    task automatic observe(input int id, input int len);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got id=%0d len=%0d expected none", id, len);
        end else begin
            e = exp_q.pop_front();
            if (e.id != id || e.len != len) begin
                errors++;
                $display("FAIL event: got id=%0d len=%0d expected id=%0d len=%0d",
                         id, len, e.id, e.len);
            end
        end
    endtask

    // Monitor: reports each completed pulse to the scoreboard
    initial begin
        logic [2:0] lows;
        for (int k = 0; k < 3; k++) run_req[k] = 0;
        for (int b = 0; b < 4; b++) run_ev[b] = 0;
        forever begin
            @(negedge clk);
            lows = ~{hps.f2h_debug_reset_req_n, hps.f2h_warm_reset_req_n,
                     hps.f2h_cold_reset_req_n};
            for (int k = 0; k < 3; k++) begin
                if (lows[k]) begin
                    run_req[k]++;
                end else if (run_req[k] != 0) begin
                    observe(k, run_req[k]);
                    run_req[k] = 0;
                end
            end
            for (int b = 0; b < 4; b++) begin
                if (stm_hwevents[b]) begin
                    run_ev[b]++;
                end else if (run_ev[b] != 0) begin
                    observe(10 + b, run_ev[b]);
                    run_ev[b] = 0;
                end
            end
            checks++;
            if ($countones(lows) > 1 || stm_hwevents[27:4] != 24'd0) begin
                errors++;
                $display("FAIL exclusive: got req_low=%b stm_hi=%h expected <=1 low, 0",
                         lows, stm_hwevents[27:4]);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // idx 0=cold 1=warm 2=debug; waits for that req_n to reach val
    task automatic wait_req(input int idx, input logic val, input int budget, input string name);
        logic v;
        int   n;
        n = 0;
        checks++;
        forever begin
            v = (idx == 0) ? hps.f2h_cold_reset_req_n :
                (idx == 1) ? hps.f2h_warm_reset_req_n : hps.f2h_debug_reset_req_n;
            if (v == val) break;
            if (n >= budget) begin
                errors++;
                $display("FAIL %s: req%0d still %b after %0d cycles expected %b",
                         name, idx, v, n, val);
                break;
            end
            @(negedge clk);
            n++;
        end
    endtask

    task automatic handshake(input int low_cycles);
        hps.h2f_reset_n = 1'b0;
        cyc(low_cycles);
        hps.h2f_reset_n = 1'b1;
        cyc(8);
    endtask

    initial begin
        int  n;
        logic saw, hs, busy_seen, warm_seen;
        int  hcnt;
        hps.h2f_reset_n = 1'b1;

        // Reset values
        cyc(3);
        chk("rst_cold_n",  hps.f2h_cold_reset_req_n, 1);
        chk("rst_warm_n",  hps.f2h_warm_reset_req_n, 1);
        chk("rst_debug_n", hps.f2h_debug_reset_req_n, 1);
        chk("rst_busy", busy, 0);
        chk("rst_led", led, 0);
        chk("rst_stm", stm_hwevents, 0);
        rst_n = 1'b1;
        cyc(3);
        chk("armed_led", led, 4'b0001);

        // Short press with bounce -> warm
        expect_ev(11, 1);
        expect_ev(1, PULSE);
        for (int i = 0; i < 6; i++) begin
            button_n[0] = i[0];
            cyc(1);
        end
        button_n[0] = 1'b0;
        cyc(20);
        button_n[0] = 1'b1;
        wait_req(1, 1'b0, 60, "warm_start");
        wait_req(1, 1'b1, 40, "warm_end");
        handshake(10);
        chk("warm_busy", busy, 0);
        chk("warm_led", led, 4'b0101);

        // Long press -> cold before release, no retrigger while held
        expect_ev(10, 1);
        expect_ev(0, PULSE);
        saw = 0; hs = 0; hcnt = 0; warm_seen = 0;
        button_n = 2'b10;
        for (int i = 0; i < 140; i++) begin
            @(negedge clk);
            if (!hps.f2h_cold_reset_req_n) saw = 1'b1;
            if (!hps.f2h_warm_reset_req_n) warm_seen = 1'b1;
            if (saw && hps.f2h_cold_reset_req_n && !hs) hs = 1'b1;
            if (hs) begin
                hps.h2f_reset_n = (hcnt < 5) ? 1'b0 : 1'b1;
                hcnt++;
            end
        end
        chk("cold_before_release", saw, 1);
        chk("cold_no_warm", warm_seen, 0);
        chk("cold_held_busy", busy, 0);
        button_n = 2'b11;
        cyc(20);
        chk("cold_led", led, 4'b0111);

        // Both buttons together -> button0 path, then button1 alone -> debug
        expect_ev(11, 1);
        expect_ev(1, PULSE);
        button_n = 2'b00;
        cyc(20);
        button_n = 2'b11;
        wait_req(1, 1'b0, 60, "both_warm_start");
        wait_req(1, 1'b1, 40, "both_warm_end");
        handshake(6);
        expect_ev(12, 1);
        expect_ev(2, PULSE);
        button_n = 2'b01;
        wait_req(2, 1'b0, 60, "debug_start");
        wait_req(2, 1'b1, 40, "debug_end");
        button_n = 2'b11;
        cyc(2);
        chk("debug_idle_busy", busy, 0);

        // Warm with no HPS response -> timeout after ACK cycles in wait states
        expect_ev(11, 1);
        expect_ev(1, PULSE);
        expect_ev(13, 1);
        button_n = 2'b10;
        cyc(10);
        button_n = 2'b11;
        wait_req(1, 1'b0, 60, "to_warm_start");
        wait_req(1, 1'b1, 40, "to_warm_end");
        n = 0;
        while (!stm_hwevents[3] && n < ACK + 60) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_cycles", n, ACK);
        chk("timeout_busy", busy, 0);
        chk("timeout_led", led, 4'b1111);

        // Disarmed: presses ignored
        dipsw = 4'b1110;
        cyc(2);
        chk("disarmed_led0", led[0], 0);
        busy_seen = 0;
        button_n = 2'b00;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 20) button_n = 2'b11;
            if (busy) busy_seen = 1'b1;
        end
        chk("disarmed_busy", busy_seen, 0);
        dipsw = 4'b0001;
        cyc(2);

        // Press during WAIT_RELEASE is discarded
        expect_ev(11, 1);
        expect_ev(1, PULSE);
        button_n = 2'b10;
        cyc(10);
        button_n = 2'b11;
        wait_req(1, 1'b0, 60, "wr_warm_start");
        wait_req(1, 1'b1, 40, "wr_warm_end");
        hps.h2f_reset_n = 1'b0;
        cyc(5);
        chk("wr_busy", busy, 1);
        button_n = 2'b10;
        cyc(20);
        button_n = 2'b11;
        cyc(10);
        hps.h2f_reset_n = 1'b1;
        cyc(100);
        chk("wr_no_pending", busy, 0);

        // Reset asserted on 5th cycle of a cold pulse
        expect_ev(10, 1);
        expect_ev(0, 5);
        button_n = 2'b10;
        wait_req(0, 1'b0, 150, "rst_cold_start");
        cyc(4);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_cold_n", hps.f2h_cold_reset_req_n, 1);
        chk("async_led", led, 0);
        chk("async_busy", busy, 0);
        button_n = 2'b11;
        cyc(3);
        rst_n = 1'b1;
        cyc(40);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_led", led, 4'b0001);

        cyc(5);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
